// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Build option: DMEM_ARB_STARVE_GUARD_EN enables the DMA starvation guard.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 18;
  localparam int DMEM_DATA_W = 8;
  localparam int STARVE_W    = 8;

  localparam logic [DMEM_ADDR_W-1:0] MMIO_SELECT_ADDR = 18'h3D08D;
  localparam logic [DMEM_ADDR_W-1:0] MMIO_SECTOR_ADDR = 18'h3D08E;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating counter of consecutive denied DMA cycles.
// Only instantiated when DMEM_ARB_STARVE_GUARD_EN is defined.
module dmem_starve_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != STARVE_W'(MAX))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q == STARVE_W'(MAX));

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data RAM arbiter: CPU load/store port vs. read-only output DMA.
// Build option: DMEM_ARB_STARVE_GUARD_EN adds a forced DMA grant after STARVE_MAX denials.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
    $error("dmem_arbiter: STARVE_MAX must be within 1..255");
  end

  logic   forced;
  owner_e owner_q, owner_d;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic starve_at_max;

  dmem_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (dma_req & ~dma_gnt),
    .clr    (dma_gnt | ~dma_req),
    .at_max (starve_at_max)
  );

  assign forced = starve_at_max & dma_req;
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (!rst) begin
      if (cpu_req && !forced) cpu_gnt = 1'b1;
      else if (dma_req)       dma_gnt = 1'b1;
    end
    if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wren  = cpu_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
    end
  end

  // Tag the granted read so the returning mem_q is steered next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    if (cpu_gnt && !cpu_we) owner_d = OWN_CPU;
    else if (dma_gnt)       owner_d = OWN_DMA;
  end

  always_ff @(posedge clk) begin
    if (rst) owner_q <= OWN_NONE;
    else     owner_q <= owner_d;
  end

  // Gating by rst drops a read still in flight when reset arrives.
  assign cpu_rvalid = !rst && owner_q == OWN_CPU;
  assign dma_rvalid = !rst && owner_q == OWN_DMA;
  assign cpu_rdata  = cpu_rvalid ? mem_q : '0;
  assign dma_rdata  = dma_rvalid ? mem_q : '0;

endmodule
